// File: rtl/pudding_chain_loader.sv
// Byte-stream to serial daisy-chain sequencer for the 128-bit DAC chain/state register pair.
// Writes shift a frame in and auto-commit it; reads capture, recirculate via chain_tail and return bytes.
module pudding_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int DIV       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    input  logic       rd_req,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    input  logic       chain_tail,
    output logic       datum,
    output logic       shift,
    output logic       transfer,
    output logic       dir,
    output logic       busy,
    output logic       frame_done,
    output logic       rd_err
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int DCW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);
    localparam logic           SHIFT_NOW = (DIV == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_W,
        S_COMMIT,
        S_CAPTURE,
        S_SHIFT_R
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]     wbyte_q, wbyte_d;
    logic [7:0]     rsr_q, rsr_d;
    logic           rd_valid_q, rd_valid_d;
    logic           datum_q, datum_d;
    logic           shift_q, shift_d;
    logic           transfer_q, transfer_d;
    logic           dir_q, dir_d;
    logic           frame_done_q, frame_done_d;
    logic           rd_err_q, rd_err_d;

    logic [2:0]     bit_nx;
    logic [DCW-1:0] div_nx;

    assign bit_nx = bit_cnt_q + 3'd1;
    assign div_nx = div_cnt_q + DCW'(1);

    assign wr_ready   = (state_q == S_IDLE) && !rd_req && !rst;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rsr_q;
    assign datum      = datum_q;
    assign shift      = shift_q;
    assign transfer   = transfer_q;
    assign dir        = dir_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;
    assign rd_err     = rd_err_q;

    // Counters describe the cycle about to appear on the pins, so every
    // strobe is computed one cycle ahead and lands from a flop.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        wbyte_d      = wbyte_q;
        rsr_d        = rsr_q;
        rd_valid_d   = rd_valid_q;
        datum_d      = datum_q;
        shift_d      = 1'b0;
        transfer_d   = 1'b0;
        dir_d        = 1'b0;
        frame_done_d = 1'b0;
        rd_err_d     = 1'b0;

        // chain_tail is taken as it stands before the shift edge
        if (shift_q && state_q == S_SHIFT_R)
            rsr_d = {rsr_q[6:0], chain_tail};

        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    if (byte_cnt_q == '0) begin
                        state_d    = S_CAPTURE;
                        transfer_d = 1'b1;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end else if (wr_valid) begin
                    wbyte_d   = wr_data;
                    state_d   = S_SHIFT_W;
                    bit_cnt_d = 3'd0;
                    div_cnt_d = '0;
                    datum_d   = wr_data[7];
                    shift_d   = SHIFT_NOW;
                end
            end

            S_SHIFT_W: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        if (byte_cnt_q == BYTE_LAST) begin
                            state_d    = S_COMMIT;
                            transfer_d = 1'b1;
                            dir_d      = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_nx;
                        datum_d   = wbyte_q[~bit_nx];
                        shift_d   = SHIFT_NOW;
                    end
                end else begin
                    div_cnt_d = div_nx;
                    shift_d   = (div_nx == DIV_LAST);
                end
            end

            S_COMMIT: begin
                byte_cnt_d   = '0;
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end

            S_CAPTURE: begin
                state_d   = S_SHIFT_R;
                bit_cnt_d = 3'd0;
                div_cnt_d = '0;
                datum_d   = chain_tail;
                shift_d   = SHIFT_NOW;
            end

            S_SHIFT_R: begin
                if (rd_valid_q) begin
                    if (rd_ready) begin
                        rd_valid_d = 1'b0;
                        if (byte_cnt_q == BYTE_LAST) begin
                            byte_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCW'(1);
                            bit_cnt_d  = 3'd0;
                            div_cnt_d  = '0;
                            datum_d    = chain_tail;
                            shift_d    = SHIFT_NOW;
                        end
                    end
                end else begin
                    // Registered recirculation relies on a quiet cycle before each shift (DIV >= 2).
                    datum_d = chain_tail;
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            rd_valid_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_nx;
                            shift_d   = SHIFT_NOW;
                        end
                    end else begin
                        div_cnt_d = div_nx;
                        shift_d   = (div_nx == DIV_LAST);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            div_cnt_q    <= '0;
            wbyte_q      <= 8'h00;
            rsr_q        <= 8'h00;
            rd_valid_q   <= 1'b0;
            datum_q      <= 1'b0;
            shift_q      <= 1'b0;
            transfer_q   <= 1'b0;
            dir_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            wbyte_q      <= wbyte_d;
            rsr_q        <= rsr_d;
            rd_valid_q   <= rd_valid_d;
            datum_q      <= datum_d;
            shift_q      <= shift_d;
            transfer_q   <= transfer_d;
            dir_q        <= dir_d;
            frame_done_q <= frame_done_d;
            rd_err_q     <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_pudding_chain_loader.sv
// Bench for pudding_chain_loader: a behavioural chain/state register pair plus byte-level frame model.
module tb_pudding_chain_loader;
    localparam int CHAIN_LEN = 128;
    localparam int DIV       = 2;
    localparam int NB        = CHAIN_LEN / 8;

    logic       clk = 1'b0, rst = 1'b1;
    logic       wr_valid = 1'b0, wr_ready, rd_req = 1'b0, rd_valid, rd_ready = 1'b0;
    logic [7:0] wr_data = 8'h00, rd_data;
    logic       chain_tail, datum, shift, transfer, dir, busy, frame_done, rd_err;

    logic [CHAIN_LEN-1:0] chain = '0, st = '0;
    assign chain_tail = chain[CHAIN_LEN-1];

    pudding_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .chain_tail(chain_tail), .datum(datum), .shift(shift), .transfer(transfer), .dir(dir),
        .busy(busy), .frame_done(frame_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, hs_cnt = 0, sh_cnt = 0, tr_cnt = 0, fd_cnt = 0, re_cnt = 0, ovl = 0;
    int tr_cyc = 0, fd_cyc = 0;
    logic tr_dir = 1'b0;
    int hs_cyc[$], sh_cyc[$];
    logic sh_dat[$], sh_tail[$];
    logic [7:0] rdq[$];
    logic [7:0] frm[NB];

    // Downstream daisy chain and state register
    always @(posedge clk) begin
        if (!rst) begin
            if (shift) chain <= {chain[CHAIN_LEN-2:0], datum};
            if (transfer) begin
                if (dir) st <= chain;
                else     chain <= st;
            end
        end
    end

    // Mid-cycle event monitor
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (wr_valid && wr_ready) begin hs_cnt++; hs_cyc.push_back(cyc); end
            if (shift) begin
                sh_cnt++; sh_cyc.push_back(cyc); sh_dat.push_back(datum); sh_tail.push_back(chain_tail);
            end
            if (transfer) begin tr_cnt++; tr_cyc = cyc; tr_dir = dir; end
            if (shift && transfer) ovl++;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (rd_err) re_cnt++;
            if (rd_valid && rd_ready) rdq.push_back(rd_data);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [16:0] outs();
        return {busy, shift, datum, transfer, dir, wr_ready, rd_valid, frame_done, rd_err, rd_data};
    endfunction

    // Frame as it should sit in the state register: first byte at the top
    function automatic logic [CHAIN_LEN-1:0] fvec();
        logic [CHAIN_LEN-1:0] v = '0;
        for (int i = 0; i < NB; i++) v = {v[CHAIN_LEN-9:0], frm[i]};
        return v;
    endfunction

    task automatic wait_wr(input string tag);
        int k = 0;
        while (wr_ready !== 1'b1 && k < 400) begin tick(); k++; end
        chk(tag, wr_ready, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin tick(); k++; end
        chk(tag, busy, 0);
    endtask

    task automatic wait_rdv(input string tag);
        int k = 0;
        while (rd_valid !== 1'b1 && k < 400) begin tick(); k++; end
        chk(tag, rd_valid, 1);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wait_wr("wr_ready_wait");
        wr_valid = 1'b1; wr_data = b;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic write_frame();
        for (int i = 0; i < NB; i++) write_byte(frm[i]);
        wait_idle("commit_wait");
        tick();
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NB; i++) frm[i] = 8'($urandom);
    endtask

    task automatic check_readback(input string tag);
        int bad = 0;
        chk({tag, "_count"}, rdq.size(), NB);
        for (int i = 0; i < NB && i < rdq.size(); i++) if (rdq[i] !== frm[i]) bad++;
        chk({tag, "_bytes"}, bad, 0);
        chk({tag, "_chain_restored"}, chain, fvec());
    endtask

    initial begin
        int s_sh, s_tr, s_fd, s_re, s_hs, bad;
        logic [7:0] v8;
        logic [31:0] pat;

        #1;
        chk("reset_outputs", outs(), 0);
        chk("reset_wr_ready", wr_ready, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("idle_wr_ready", wr_ready, 1);
        chk("idle_busy", busy, 0);

        // Frame 0x00..0x0F
        for (int i = 0; i < NB; i++) frm[i] = 8'(i);
        s_sh = sh_cnt; s_tr = tr_cnt; s_fd = fd_cnt;
        hs_cyc.delete(); sh_cyc.delete();
        write_frame();
        chk("f1_shifts", sh_cnt - s_sh, CHAIN_LEN);
        chk("f1_transfers", tr_cnt - s_tr, 1);
        chk("f1_dir", tr_dir, 1);
        chk("f1_frame_done", fd_cnt - s_fd, 1);
        chk("f1_frame_done_cycle", fd_cyc - tr_cyc, 1);
        chk("f1_latency", sh_cyc[0] - hs_cyc[0], DIV);
        chk("f1_commit_after_last_shift", tr_cyc > sh_cyc[CHAIN_LEN-1], 1);
        bad = 0;
        for (int i = 1; i < sh_cyc.size(); i++)
            if (i % 8 != 0 && sh_cyc[i] - sh_cyc[i-1] != DIV) bad++;
        chk("f1_shift_spacing", bad, 0);
        chk("f1_frame_cycles", tr_cyc - hs_cyc[0] + 1, NB * (8 * DIV + 1) + 1);
        chk("f1_state_literal", st, 128'h000102030405060708090a0b0c0d0e0f);

        // Single byte 0xA5 opens a partial frame
        s_sh = sh_cnt; s_tr = tr_cnt;
        sh_dat.delete();
        frm[0] = 8'hA5;
        write_byte(frm[0]);
        wait_idle("a5_idle");
        tick();
        v8 = 8'h00;
        for (int i = 0; i < sh_dat.size(); i++) v8 = {v8[6:0], sh_dat[i]};
        chk("a5_shifts", sh_cnt - s_sh, 8);
        chk("a5_datum_seq", v8, 8'hA5);
        chk("a5_no_transfer", tr_cnt - s_tr, 0);

        // Reject readback with 3 of 16 bytes written
        for (int i = 1; i < 3; i++) begin frm[i] = 8'($urandom); write_byte(frm[i]); end
        wait_idle("partial_idle");
        s_tr = tr_cnt; s_re = re_cnt;
        rd_req = 1'b1;
        #1 chk("rdreq_blocks_wr_ready", wr_ready, 0);
        tick();
        rd_req = 1'b0;
        tick();
        chk("rej_rd_err", re_cnt - s_re, 1);
        chk("rej_no_transfer", tr_cnt - s_tr, 0);
        chk("rej_wr_ready_back", wr_ready, 1);
        chk("rej_not_busy", busy, 0);

        // Finish the partial frame; it commits only now
        for (int i = 3; i < NB; i++) frm[i] = 8'($urandom);
        for (int i = 3; i < NB; i++) write_byte(frm[i]);
        wait_idle("partial_commit_wait");
        tick();
        chk("partial_one_commit", tr_cnt - s_tr, 1);
        chk("partial_state", st, fvec());

        // 0xDEADBEEF frame then free-running readback
        pat = 32'hDEADBEEF;
        for (int i = 0; i < NB; i++) frm[i] = pat[31 - 8 * (i % 4) -: 8];
        write_frame();
        chk("dead_state", st, fvec());
        rd_ready = 1'b1;
        s_sh = sh_cnt; s_tr = tr_cnt; s_fd = fd_cnt;
        rdq.delete(); sh_dat.delete(); sh_tail.delete();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_idle("rb_wait");
        tick();
        chk("rb_transfers", tr_cnt - s_tr, 1);
        chk("rb_dir", tr_dir, 0);
        chk("rb_shifts", sh_cnt - s_sh, CHAIN_LEN);
        chk("rb_no_frame_done", fd_cnt - s_fd, 0);
        chk("rb_first_byte", rdq.size() > 0 ? rdq[0] : 8'hxx, 8'hDE);
        bad = 0;
        for (int i = 0; i < sh_dat.size(); i++) if (sh_dat[i] !== sh_tail[i]) bad++;
        chk("rb_datum_is_tail", bad, 0);
        check_readback("rb");

        // Random frame, readback with a 20-cycle consumer stall on byte 2
        rand_frame();
        write_frame();
        rd_ready = 1'b0;
        rdq.delete();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_rdv("stall_byte1");
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_rdv("stall_byte2");
        s_sh = sh_cnt;
        repeat (20) tick();
        chk("stall_no_shift", sh_cnt - s_sh, 0);
        chk("stall_valid_held", rd_valid, 1);
        chk("stall_byte2_data", rd_data, frm[1]);
        rd_ready = 1'b1;
        wait_idle("stall_wait");
        tick();
        check_readback("stall");

        // rd_req and wr_valid together in IDLE with an empty frame
        s_hs = hs_cnt;
        rdq.delete();
        rd_req = 1'b1; wr_valid = 1'b1; wr_data = 8'($urandom);
        #1 chk("same_wr_ready_low", wr_ready, 0);
        tick();
        rd_req = 1'b0; wr_valid = 1'b0;
        chk("same_busy", busy, 1);
        wait_idle("same_wait");
        tick();
        chk("same_no_write", hs_cnt - s_hs, 0);
        check_readback("same");

        // Reset in the middle of a byte, then a fresh full frame
        wait_wr("mid_wr_ready");
        wr_valid = 1'b1; wr_data = 8'h3C;
        tick();
        wr_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1 chk("mid_reset_outputs", outs(), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {busy, wr_ready}, 2'b01);
        rand_frame();
        s_sh = sh_cnt; s_tr = tr_cnt; s_fd = fd_cnt;
        write_frame();
        chk("post_reset_shifts", sh_cnt - s_sh, CHAIN_LEN);
        chk("post_reset_one_commit", tr_cnt - s_tr, 1);
        chk("post_reset_dir", tr_dir, 1);
        chk("post_reset_frame_done", fd_cnt - s_fd, 1);
        chk("post_reset_state", st, fvec());

        chk("shift_transfer_overlap", ovl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
